// File: rtl/pong_pkg.sv
// Shared Pong types, default constants and the BCD increment helper.
// Consumed by lives_score_tracker (HIGH_SCORE_EN build option) and bcd_counter4.
package pong_pkg;

    localparam int unsigned DEFAULT_INIT_LIVES          = 3;
    localparam int unsigned DEFAULT_MISS_HOLDOFF_FRAMES = 60;

    typedef logic [3:0] bcd_t;

    localparam logic [1:0] ST_PLAY = 2'd0;
    localparam logic [1:0] ST_HOLD = 2'd1;
    localparam logic [1:0] ST_OVER = 2'd2;

    // Four-digit packed BCD +1; 9999 wraps to 0000.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        bcd_t        d;
        r     = v;
        carry = 1'b1;
        for (int unsigned i = 0; i < 4; i++) begin
            d = v[4*i +: 4];
            if (carry) begin
                if (d == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = d + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/lives_score_tracker_bcd_counter4.sv
// bcd_counter4: four-digit synchronous BCD incrementer with sync clear, wraps at 9999.
module bcd_counter4
    import pong_pkg::*;
(
    input  logic        clk_i,
    input  logic        clr_i,
    input  logic        inc_i,
    output logic [15:0] q_o
);

    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = bcd_inc(cnt_q);
        end
    end

    always_ff @(posedge clk_i) begin
        cnt_q <= cnt_d;
    end

    assign q_o = cnt_q;

endmodule

// File: rtl/lives_score_tracker.sv
// Pong lives/score tracker with post-miss frame holdoff feeding GameControl_top.
// Build option: define HIGH_SCORE_EN to add the HighScore port and register.
module lives_score_tracker
    import pong_pkg::*;
#(
    parameter int unsigned INIT_LIVES          = DEFAULT_INIT_LIVES,
    parameter int unsigned MISS_HOLDOFF_FRAMES = DEFAULT_MISS_HOLDOFF_FRAMES
)(
    input  logic        Clk_100MHz,
    input  logic        Reset,
    input  logic        Game_Enable,
    input  logic        GameTimer_Reset,
    input  logic        VMA_busy,
    input  logic        ballMiss,
    input  logic        paddleHit,
    output logic [1:0]  LivesCount,
    output logic [15:0] Score,
    output logic        MissHold,
    output logic        GameOver
`ifdef HIGH_SCORE_EN
    ,
    output logic [15:0] HighScore
`endif
);

    logic       vma_q, miss_q, hit_q;
    logic       vma_edge, miss_edge, hit_edge;
    logic       new_game;
    logic [1:0] state_q, state_d;
    logic [1:0] lives_q, lives_d;
    logic [5:0] cnt_q, cnt_d;
    logic       hold_q, hold_d;
    logic       over_q, over_d;
    logic       score_inc;

    assign vma_edge  = VMA_busy  & ~vma_q;
    assign miss_edge = ballMiss  & ~miss_q;
    assign hit_edge  = paddleHit & ~hit_q;
    assign new_game  = Reset | GameTimer_Reset;

    always_comb begin
        state_d   = state_q;
        lives_d   = lives_q;
        cnt_d     = cnt_q;
        hold_d    = hold_q;
        over_d    = over_q;
        score_inc = 1'b0;
        if (new_game) begin
            state_d = ST_PLAY;
            lives_d = INIT_LIVES[1:0];
            cnt_d   = '0;
            hold_d  = 1'b0;
            over_d  = 1'b0;
        end else begin
            case (state_q)
                ST_PLAY: begin
                    score_inc = Game_Enable & hit_edge;
                    if (Game_Enable && miss_edge) begin
                        lives_d = lives_q - 2'd1;
                        if (lives_q == 2'd1) begin
                            state_d = ST_OVER;
                            over_d  = 1'b1;
                        end else begin
                            state_d = ST_HOLD;
                            cnt_d   = '0;
                            hold_d  = 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (Game_Enable && vma_edge) begin
                        cnt_d = cnt_q + 6'd1;
                        if (cnt_d == MISS_HOLDOFF_FRAMES[5:0]) begin
                            state_d = ST_PLAY;
                            hold_d  = 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clk_100MHz) begin
        if (Reset) begin
            vma_q   <= 1'b0;
            miss_q  <= 1'b0;
            hit_q   <= 1'b0;
            state_q <= ST_PLAY;
            lives_q <= INIT_LIVES[1:0];
            cnt_q   <= '0;
            hold_q  <= 1'b0;
            over_q  <= 1'b0;
        end else begin
            vma_q   <= VMA_busy;
            miss_q  <= ballMiss;
            hit_q   <= paddleHit;
            state_q <= state_d;
            lives_q <= lives_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            over_q  <= over_d;
        end
    end

    bcd_counter4 u_score (
        .clk_i (Clk_100MHz),
        .clr_i (new_game),
        .inc_i (score_inc),
        .q_o   (Score)
    );

`ifdef HIGH_SCORE_EN
    logic [15:0] hs_q, hs_d;
    logic [15:0] score_after;

    // A hit in the losing cycle counts toward the final score being compared.
    always_comb begin
        hs_d        = hs_q;
        score_after = score_inc ? bcd_inc(Score) : Score;
        if (!new_game && state_q == ST_PLAY && state_d == ST_OVER && score_after > hs_q) begin
            hs_d = score_after;
        end
    end

    always_ff @(posedge Clk_100MHz) begin
        if (Reset) begin
            hs_q <= '0;
        end else begin
            hs_q <= hs_d;
        end
    end

    assign HighScore = hs_q;
`endif

    assign LivesCount = lives_q;
    assign MissHold   = hold_q;
    assign GameOver   = over_q;

endmodule

// File: tb/tb_lives_score_tracker.sv
// Self-checking bench for lives_score_tracker: per-cycle model compare plus literal pins.
module tb_lives_score_tracker;

    localparam int INIT  = 3;
    localparam int HOLDF = 60;

    logic        clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Game_Enable = 1'b0;
    logic        GameTimer_Reset = 1'b0;
    logic        VMA_busy = 1'b0;
    logic        ballMiss = 1'b0;
    logic        paddleHit = 1'b0;
    logic [1:0]  LivesCount;
    logic [15:0] Score;
    logic        MissHold;
    logic        GameOver;
`ifdef HIGH_SCORE_EN
    logic [15:0] HighScore;
`endif

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    int m_lives = INIT;
    int m_score = 0;
    int m_left  = 0;
    int m_hs    = 0;
    bit mp_vma = 1'b0, mp_miss = 1'b0, mp_hit = 1'b0;

    lives_score_tracker #(
        .INIT_LIVES          (INIT),
        .MISS_HOLDOFF_FRAMES (HOLDF)
    ) dut (
        .Clk_100MHz      (clk),
        .Reset           (Reset),
        .Game_Enable     (Game_Enable),
        .GameTimer_Reset (GameTimer_Reset),
        .VMA_busy        (VMA_busy),
        .ballMiss        (ballMiss),
        .paddleHit       (paddleHit),
        .LivesCount      (LivesCount),
        .Score           (Score),
        .MissHold        (MissHold),
        .GameOver        (GameOver)
`ifdef HIGH_SCORE_EN
        ,
        .HighScore       (HighScore)
`endif
    );

    always #5 clk = ~clk;

    function automatic int to_bcd(input int v);
        return ((v / 1000) % 10) * 4096 + ((v / 100) % 10) * 256 + ((v / 10) % 10) * 16 + (v % 10);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Game rules: lives==0 means over, m_left>0 means holdoff frames remaining.
    always @(posedge clk) begin : model
        bit ev_v, ev_m, ev_h;
        ev_v = VMA_busy && !mp_vma;
        ev_m = ballMiss && !mp_miss;
        ev_h = paddleHit && !mp_hit;
        if (Reset || GameTimer_Reset) begin
            m_lives = INIT;
            m_score = 0;
            m_left  = 0;
            if (Reset) m_hs = 0;
        end else if (m_lives == 0) begin
        end else if (m_left > 0) begin
            if (Game_Enable && ev_v) m_left = m_left - 1;
        end else if (Game_Enable) begin
            if (ev_h) m_score = (m_score + 1) % 10000;
            if (ev_m) begin
                m_lives = m_lives - 1;
                if (m_lives > 0) m_left = HOLDF;
                else if (m_score > m_hs) m_hs = m_score;
            end
        end
        if (Reset) begin
            mp_vma = 1'b0; mp_miss = 1'b0; mp_hit = 1'b0;
        end else begin
            mp_vma = VMA_busy; mp_miss = ballMiss; mp_hit = paddleHit;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_lives", int'(LivesCount), m_lives);
            chk("model_score", int'(Score), to_bcd(m_score));
            chk("model_misshold", int'(MissHold), int'(m_left > 0));
            chk("model_gameover", int'(GameOver), int'(m_lives == 0));
`ifdef HIGH_SCORE_EN
            chk("model_highscore", int'(HighScore), to_bcd(m_hs));
`endif
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_miss();
        ballMiss = 1'b1; tick(1); ballMiss = 1'b0; tick(1);
    endtask

    task automatic hits(input int n);
        for (int i = 0; i < n; i++) begin
            paddleHit = 1'b1; tick(1); paddleHit = 1'b0; tick(1);
        end
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            VMA_busy = 1'b1; tick(1); VMA_busy = 1'b0; tick(1);
        end
    endtask

    task automatic new_game();
        GameTimer_Reset = 1'b1; tick(1); GameTimer_Reset = 1'b0; tick(1);
    endtask

    task automatic lose_game();
        pulse_miss(); frames(HOLDF);
        pulse_miss(); frames(HOLDF);
        pulse_miss();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(2);
        Reset = 1'b0;
        chk_en = 1'b1;
        chk("reset_lives", int'(LivesCount), 3);
        chk("reset_score", int'(Score), 'h0000);
        chk("reset_hold", int'(MissHold), 0);
        chk("reset_over", int'(GameOver), 0);
`ifdef HIGH_SCORE_EN
        chk("reset_hs", int'(HighScore), 'h0000);
`endif

        Game_Enable = 1'b1;
        ballMiss = 1'b1; tick(1);
        chk("miss_lives", int'(LivesCount), 2);
        chk("miss_hold", int'(MissHold), 1);
        ballMiss = 1'b0; tick(1);
        pulse_miss();
        chk("miss_in_hold", int'(LivesCount), 2);
        frames(HOLDF - 1);
        chk("hold_59", int'(MissHold), 1);
        frames(1);
        chk("hold_60", int'(MissHold), 0);

        hits(10);
        chk("score_carry", int'(Score), 'h0010);

        Game_Enable = 1'b0;
        hits(1);
        pulse_miss();
        chk("gated_score", int'(Score), 'h0010);
        chk("gated_lives", int'(LivesCount), 2);
        Game_Enable = 1'b1;
        pulse_miss();
        chk("miss2_lives", int'(LivesCount), 1);
        Game_Enable = 1'b0;
        frames(HOLDF);
        chk("gated_frames", int'(MissHold), 1);
        Game_Enable = 1'b1;
        frames(HOLDF);
        chk("hold_release", int'(MissHold), 0);

        pulse_miss();
        chk("over_lives", int'(LivesCount), 0);
        chk("over_flag", int'(GameOver), 1);
        hits(1);
        pulse_miss();
        chk("over_score", int'(Score), 'h0010);
`ifdef HIGH_SCORE_EN
        chk("over_hs", int'(HighScore), 'h0010);
`endif

        new_game();
        chk("gtr_lives", int'(LivesCount), 3);
        chk("gtr_over", int'(GameOver), 0);

        ballMiss = 1'b1; paddleHit = 1'b1; tick(1);
        ballMiss = 1'b0; paddleHit = 1'b0; tick(1);
        chk("simul_score", int'(Score), 'h0001);
        chk("simul_lives", int'(LivesCount), 2);
        frames(HOLDF);

        ballMiss = 1'b1; tick(5);
        ballMiss = 1'b0; tick(1);
        chk("held_miss", int'(LivesCount), 1);

        GameTimer_Reset = 1'b1; ballMiss = 1'b1; tick(1);
        GameTimer_Reset = 1'b0; ballMiss = 1'b0; tick(1);
        chk("prio_lives", int'(LivesCount), 3);
        chk("prio_score", int'(Score), 'h0000);
        chk("prio_hold", int'(MissHold), 0);

        hits(9999);
        chk("score_9999", int'(Score), 'h9999);
        hits(1);
        chk("score_wrap", int'(Score), 'h0000);

        new_game();
        hits(12);
        lose_game();
        chk("game12_score", int'(Score), 'h0012);
        chk("game12_over", int'(GameOver), 1);
`ifdef HIGH_SCORE_EN
        chk("hs_12", int'(HighScore), 'h0012);
`endif
        new_game();
        hits(5);
        lose_game();
        chk("game5_score", int'(Score), 'h0005);
`ifdef HIGH_SCORE_EN
        chk("hs_keep", int'(HighScore), 'h0012);
`endif
        new_game();
`ifdef HIGH_SCORE_EN
        chk("hs_gtr", int'(HighScore), 'h0012);
`endif
        Reset = 1'b1; tick(1); Reset = 1'b0; tick(1);
        chk("rst_lives", int'(LivesCount), 3);
`ifdef HIGH_SCORE_EN
        chk("hs_reset", int'(HighScore), 'h0000);
`endif

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lives_score_tracker.md
# lives_score_tracker

Tracks lives remaining and the rally score for one Pong game and produces the `LivesCount` value consumed by `GameControl_top`. It sits directly upstream of the game controller and directly downstream of the ball/paddle physics, which report misses and paddle hits as single-cycle or level events. It also gates events with the controller's `Game_Enable`, and restarts on its `GameTimer_Reset`. Holdoff timing after a miss is counted in video frames using `VMA_busy`.

## Interface
- `INIT_LIVES`, 3: lives loaded at reset and at new game; legal range 1–3.
- `MISS_HOLDOFF_FRAMES`, 60: frames during which events are ignored after a miss; legal range 1–63.
- `Clk_100MHz`  in  1  system clock; all logic on its rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `Game_Enable`  in  1  from `GameControl_top`; when 0, events are ignored and holdoff is frozen.
- `GameTimer_Reset`  in  1  from `GameControl_top`; when 1 in a cycle, a new game starts (same effect as `Reset`, except high score).
- `VMA_busy`  in  1  vsync/frame-busy level; each rising edge is one frame tick.
- `ballMiss`  in  1  ball passed the paddle; a rising edge is one miss.
- `paddleHit`  in  1  ball struck the paddle; a rising edge is one hit.
- `LivesCount`  out  2  lives remaining, to `GameControl_top`.
- `Score`  out  16  four BCD digits, [15:12] most significant.
- `MissHold`  out  1  high during holdoff; used for the display blink.
- `GameOver`  out  1  high when lives reach 0.
- `HighScore`  out  16  BCD; present only with `HIGH_SCORE_EN`.

## Operation
- **Edge detection.** One previous-value register for each of `VMA_busy`, `ballMiss` and `paddleHit`.
  - `edge = in & ~prev`, evaluated combinationally.
  - The previous-value registers reset to 0.
- **FSM states:** PLAY, HOLD, OVER. Reset state is PLAY.
- **PLAY:**
  - A miss edge with `Game_Enable=1` decrements `LivesCount`.
  - If the new value is 0, go to OVER and set `GameOver=1`.
  - Otherwise go to HOLD, clear the frame counter and set `MissHold=1`.
  - A hit edge with `Game_Enable=1` increments `Score`.
- **HOLD:**
  - Miss and hit edges are ignored.
  - The frame counter (6 bits) increments on each `VMA_busy` edge, but only while `Game_Enable=1`.
  - When the counter reaches `MISS_HOLDOFF_FRAMES`, go to PLAY and clear `MissHold`.
- **OVER:** all events are ignored and outputs hold. Only `Reset` or `GameTimer_Reset` exits, to PLAY.
- **Simultaneous miss and hit in PLAY:** both are applied in the same cycle — score increments and the life is lost.
- **Reset or `GameTimer_Reset`** has priority over every event in the same cycle. Either one:
  - loads `LivesCount=INIT_LIVES`;
  - clears `Score`, the frame counter, `MissHold` and `GameOver`;
  - sets state to PLAY.
- **Score arithmetic:** BCD, with a carry from digit to digit at 9. 9999 wraps to 0000. No other digit value is ever produced.
- **`LivesCount`** never underflows; a decrement happens only in PLAY, where the value is at least 1.

## Timing
- All outputs are registered.
- An event's effect is visible one clock after the first cycle in which the input is high while its previous value was 0.
- Holding `ballMiss` high for many cycles counts one miss; the line must return low and rise again for another.
- Reset values:
  - `LivesCount = INIT_LIVES`
  - `Score = 16'h0000`
  - `MissHold = 0`
  - `GameOver = 0`
  - `HighScore = 16'h0000`
- The HOLD→PLAY transition is registered on the clock edge at which the `MISS_HOLDOFF_FRAMES`-th frame edge is seen.
- `Reset` or `GameTimer_Reset` asserted mid-HOLD aborts the holdoff on the next edge.

## Configuration
- **`HIGH_SCORE_EN` defined:**
  - Adds the `HighScore` port and register.
  - On entry to OVER, `HighScore` takes `Score` if `Score` is greater than `HighScore`, compared as unsigned packed BCD.
  - Cleared only by `Reset`; `GameTimer_Reset` does not touch it.
- **`HIGH_SCORE_EN` undefined:** the port and register are absent; all other behaviour is identical.

## Structure
- **Shared `pong_pkg`:**
  - state enum (PLAY/HOLD/OVER);
  - 4-bit BCD digit typedef;
  - default constants `INIT_LIVES=3` and `MISS_HOLDOFF_FRAMES=60`.
- **Sub-module `bcd_counter4`:** 4-digit synchronous BCD incrementer with an `inc` enable, a sync clear and wrap at 9999. It is used for `Score`.

## Test plan
- **Reset.** `Reset` for 2 cycles → `LivesCount=3`, `Score=0000`, `GameOver=0`, `MissHold=0`.
- **Miss and holdoff.**
  - `Game_Enable=1`, one `ballMiss` pulse → `LivesCount=2` one clock later and `MissHold=1`.
  - A further `ballMiss` pulse inside HOLD leaves `LivesCount=2`.
  - After 60 `VMA_busy` rising edges → `MissHold=0`.
- **Game over.** Three separated misses, each followed by the full holdoff → `LivesCount=0`, `GameOver=1`. A subsequent `paddleHit` leaves `Score` unchanged.
- **Score carry and wrap.**
  - 10 hits → `Score=16'h0010`.
  - Preload to 9999 via hits, then one more hit → `16'h0000`.
- **Gating and priority.**
  - `Game_Enable=0` with hit and miss pulses → no change; `VMA_busy` edges do not advance the holdoff.
  - `GameTimer_Reset` in the same cycle as a miss → `LivesCount=3`, `Score=0000`.
- **`HIGH_SCORE_EN`.**
  - Game with score 0012 ends → `HighScore=0012`.
  - Next game ends at 0005 → `HighScore` stays 0012.
  - `GameTimer_Reset` keeps `HighScore`; `Reset` clears it.
